// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// default WAIT timeout.
package rv32i_types;

    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2,
        DMEM_TURN = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Bus bundle between the commit-side requester, the responder and the
// backing memory.
interface dmem_responder_if;

    // Handshake: data_read/data_write are level requests held by the requester
    // until it sees the one-cycle data_mem_resp pulse; mem_read/mem_write are
    // held by the responder until the memory answers with a one-cycle mem_resp.
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic        data_mem_resp;
    logic [31:0] data_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        timeout_err;

    modport slave (
        input  data_read, data_write, data_addr, data_wdata, data_mbe,
        input  mem_resp, mem_rdata,
        output data_mem_resp, data_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        output busy, timeout_err
    );

    modport master (
        output data_read, data_write, data_addr, data_wdata, data_mbe,
        output mem_resp, mem_rdata,
        input  data_mem_resp, data_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        input  busy, timeout_err
    );

endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches a commit-side request,
// drives it to backing memory, and returns a one-cycle completion pulse.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output dmem_state_t       state_dbg
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_read_q, op_read_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mbe_q, mbe_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              terr_q, terr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= '0;
            op_read_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mbe_q     <= '0;
            rdata_q   <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_read_q <= op_read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mbe_q     <= mbe_d;
            rdata_q   <= rdata_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_read_d = op_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mbe_d     = mbe_q;
        rdata_d   = rdata_q;
        terr_d    = terr_q;
        unique case (state_q)
            DMEM_IDLE: begin
                if (bus.data_read || bus.data_write) begin
                    // A simultaneous read and write is treated as a plain load.
                    op_read_d = bus.data_read;
                    addr_d    = {bus.data_addr[31:2], 2'b00};
                    wdata_d   = bus.data_wdata;
                    mbe_d     = bus.data_mbe;
                    cnt_d     = '0;
                    state_d   = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_resp) begin
                    if (op_read_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = DMEM_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d = 1'b1;
                    if (op_read_q) begin
                        rdata_d = '0;
                    end
                    state_d = DMEM_RESP;
                end
            end
            DMEM_RESP: state_d = DMEM_TURN;
            DMEM_TURN: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    // Every output decodes from state or latched registers, never from inputs.
    always_comb begin
        bus.mem_read      = (state_q == DMEM_WAIT) && op_read_q;
        bus.mem_write     = (state_q == DMEM_WAIT) && !op_read_q;
        bus.mem_addr      = addr_q;
        bus.mem_wdata     = wdata_q;
        bus.mem_mbe       = mbe_q;
        bus.data_mem_resp = (state_q == DMEM_RESP);
        bus.data_rdata    = rdata_q;
        bus.busy          = (state_q != DMEM_IDLE);
        bus.timeout_err   = terr_q;
        state_dbg         = state_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: load, store, zero-mbe store, timeout,
// simultaneous read+write with a sticky requester, and reset mid-transaction.
module tb_dmem_responder;
    import rv32i_types::*;

    logic clk;
    logic rst;
    dmem_state_t state_dbg;
    int vectors;
    int miscompares;

    dmem_responder_if bus_if ();

    dmem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(bus_if.busy), 32'd0);
        check({tag, "_mrd"},   32'(bus_if.mem_read), 32'd0);
        check({tag, "_mwr"},   32'(bus_if.mem_write), 32'd0);
        check({tag, "_resp"},  32'(bus_if.data_mem_resp), 32'd0);
        check({tag, "_rdata"}, bus_if.data_rdata, 32'h0);
        check({tag, "_maddr"}, bus_if.mem_addr, 32'h0);
        check({tag, "_mwd"},   bus_if.mem_wdata, 32'h0);
        check({tag, "_mbe"},   32'(bus_if.mem_mbe), 32'h0);
        check({tag, "_terr"},  32'(bus_if.timeout_err), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(DMEM_IDLE));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        bus_if.data_read  = 1'b0;
        bus_if.data_write = 1'b0;
        bus_if.data_addr  = 32'h0;
        bus_if.data_wdata = 32'h0;
        bus_if.data_mbe   = 4'h0;
        bus_if.mem_resp   = 1'b0;
        bus_if.mem_rdata  = 32'h0;

        // Reset
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        tick();

        // Load with mem_resp three cycles after mem_read rises
        bus_if.data_read = 1'b1;
        bus_if.data_addr = 32'h1000_0006;
        tick();
        check("ld_mrd", 32'(bus_if.mem_read), 32'd1);
        check("ld_mwr", 32'(bus_if.mem_write), 32'd0);
        check("ld_maddr", bus_if.mem_addr, 32'h1000_0004);
        check("ld_busy", 32'(bus_if.busy), 32'd1);
        check("ld_noresp", 32'(bus_if.data_mem_resp), 32'd0);
        tick();
        check("ld_mrd2", 32'(bus_if.mem_read), 32'd1);
        tick();
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus_if.mem_resp  = 1'b0;
        bus_if.mem_rdata = 32'h0;
        check("ld_resp", 32'(bus_if.data_mem_resp), 32'd1);
        check("ld_rdata", bus_if.data_rdata, 32'hDEAD_BEEF);
        check("ld_mrd_drop", 32'(bus_if.mem_read), 32'd0);
        tick();
        bus_if.data_read = 1'b0;
        check("ld_resp_once", 32'(bus_if.data_mem_resp), 32'd0);
        check("ld_turn", 32'(state_dbg), 32'(DMEM_TURN));
        check("ld_turn_busy", 32'(bus_if.busy), 32'd1);
        tick();
        check("ld_idle_busy", 32'(bus_if.busy), 32'd0);

        // Store, byte enables 0011, memory answers after three WAIT cycles
        bus_if.data_write = 1'b1;
        bus_if.data_addr  = 32'h2000_0003;
        bus_if.data_wdata = 32'h1234_5678;
        bus_if.data_mbe   = 4'b0011;
        tick();
        check("st_mwr", 32'(bus_if.mem_write), 32'd1);
        check("st_mrd", 32'(bus_if.mem_read), 32'd0);
        check("st_maddr", bus_if.mem_addr, 32'h2000_0000);
        check("st_mwd", bus_if.mem_wdata, 32'h1234_5678);
        check("st_mbe", 32'(bus_if.mem_mbe), 32'h3);
        bus_if.data_wdata = 32'hFFFF_FFFF;
        bus_if.data_mbe   = 4'hF;
        tick();
        check("st_mwd_stable", bus_if.mem_wdata, 32'h1234_5678);
        check("st_mwr_held", 32'(bus_if.mem_write), 32'd1);
        tick();
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus_if.mem_resp  = 1'b0;
        check("st_resp", 32'(bus_if.data_mem_resp), 32'd1);
        check("st_rdata_keep", bus_if.data_rdata, 32'hDEAD_BEEF);
        check("st_mwr_drop", 32'(bus_if.mem_write), 32'd0);
        tick();
        bus_if.data_write = 1'b0;
        check("st_resp_once", 32'(bus_if.data_mem_resp), 32'd0);
        tick();

        // Store with all byte enables clear still reaches memory
        bus_if.data_write = 1'b1;
        bus_if.data_addr  = 32'h0000_0104;
        bus_if.data_wdata = 32'hA5A5_0000;
        bus_if.data_mbe   = 4'h0;
        tick();
        check("z_mwr", 32'(bus_if.mem_write), 32'd1);
        check("z_mbe", 32'(bus_if.mem_mbe), 32'h0);
        bus_if.mem_resp = 1'b1;
        tick();
        bus_if.mem_resp = 1'b0;
        check("z_resp", 32'(bus_if.data_mem_resp), 32'd1);
        tick();
        bus_if.data_write = 1'b0;
        tick();

        // Timeout: memory never answers; requester drops its strobe early
        bus_if.data_read = 1'b1;
        bus_if.data_addr = 32'h0000_0030;
        tick();
        bus_if.data_read = 1'b0;
        check("to_mrd_c1", 32'(bus_if.mem_read), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check($sformatf("to_mrd_c%0d", i), 32'(bus_if.mem_read), 32'd1);
        end
        check("to_terr_pre", 32'(bus_if.timeout_err), 32'd0);
        tick();
        check("to_mrd_drop", 32'(bus_if.mem_read), 32'd0);
        check("to_resp", 32'(bus_if.data_mem_resp), 32'd1);
        check("to_terr", 32'(bus_if.timeout_err), 32'd1);
        check("to_rdata", bus_if.data_rdata, 32'h0);
        tick();
        tick();
        check("to_idle", 32'(bus_if.busy), 32'd0);
        check("to_terr_sticky", 32'(bus_if.timeout_err), 32'd1);

        // Read and write together, requester holds both through TURN
        bus_if.data_read  = 1'b1;
        bus_if.data_write = 1'b1;
        bus_if.data_addr  = 32'h0000_0040;
        tick();
        check("rw_mrd", 32'(bus_if.mem_read), 32'd1);
        check("rw_mwr", 32'(bus_if.mem_write), 32'd0);
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus_if.mem_resp = 1'b0;
        check("rw_resp", 32'(bus_if.data_mem_resp), 32'd1);
        check("rw_rdata", bus_if.data_rdata, 32'h0BAD_F00D);
        tick();
        check("rw_turn", 32'(state_dbg), 32'(DMEM_TURN));
        tick();
        check("rw_no_reissue_busy", 32'(bus_if.busy), 32'd0);
        check("rw_no_reissue_mrd", 32'(bus_if.mem_read), 32'd0);
        bus_if.data_read  = 1'b0;
        bus_if.data_write = 1'b0;
        tick();
        check("rw_still_idle", 32'(bus_if.busy), 32'd0);

        // Asynchronous reset during WAIT, then a late mem_resp
        bus_if.data_read = 1'b1;
        bus_if.data_addr = 32'h0000_0050;
        tick();
        check("ar_mrd", 32'(bus_if.mem_read), 32'd1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("ar");
        bus_if.data_read = 1'b0;
        tick();
        rst = 1'b1;
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'h5555_AAAA;
        tick();
        bus_if.mem_resp = 1'b0;
        check("ar_no_resp", 32'(bus_if.data_mem_resp), 32'd0);
        check("ar_busy", 32'(bus_if.busy), 32'd0);
        check("ar_rdata", bus_if.data_rdata, 32'h0);
        tick();
        check("ar_no_resp2", 32'(bus_if.data_mem_resp), 32'd0);
        check("ar_state", 32'(state_dbg), 32'(DMEM_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles in WAIT before forced completion.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 data_read  input  1  commit-side load request, level-held until data_mem_resp.
REQ-005 data_write  input  1  commit-side store request, level-held until data_mem_resp.
REQ-006 data_addr  input  32  byte address of request.
REQ-007 data_wdata  input  32  store data.
REQ-008 data_mbe  input  4  store byte enables.
REQ-009 data_mem_resp  output  1  single-cycle completion pulse to requester.
REQ-010 data_rdata  output  32  load data, valid when data_mem_resp=1.
REQ-011 mem_read, mem_write  output  1 each  backing-memory request strobes, level-held.
REQ-012 mem_addr  output  32  word-aligned backing-memory address.
REQ-013 mem_wdata  output  32; mem_mbe  output  4  latched store data and enables.
REQ-014 mem_resp  input  1; mem_rdata  input  32  backing-memory completion and load data.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  sticky flag, set on any timeout.

Function
REQ-017 FSM states IDLE, WAIT, RESP, TURN; all outputs registered or decoded from state/latched registers only, none combinational from inputs.
REQ-018 IDLE: on data_read or data_write, latch op, {data_addr[31:2],2'b00}, data_wdata, data_mbe, clear timeout counter; go WAIT.
REQ-019 Both data_read and data_write high in IDLE: read wins, write ignored, no error.
REQ-020 WAIT: mem_read=1 (load) or mem_write=1 (store); mem_addr/mem_wdata/mem_mbe stable from latches; counter increments each cycle.
REQ-021 WAIT with mem_resp=1: capture mem_rdata into data_rdata on loads (stores leave data_rdata unchanged); strobes low next cycle; go RESP.
REQ-022 WAIT with counter == TIMEOUT_CYCLES-1 and no mem_resp: set timeout_err, load data_rdata=32'h0 (loads only), go RESP.
REQ-023 RESP: data_mem_resp=1 for exactly one cycle; go TURN.
REQ-024 TURN: one cycle, requests ignored (requester clears its registered strobe this cycle); go IDLE.
REQ-025 Latency: request seen at edge N -> mem strobe high cycle N+1; mem_resp in cycle N+k -> data_mem_resp in cycle N+k+1; back-to-back throughput one request per 4 cycles minimum.
REQ-026 Requester dropping data_read/data_write during WAIT does not abort; transaction completes and data_mem_resp still pulses.
REQ-027 mem_mbe=4'h0 stores are still issued to backing memory.
REQ-028 Timeout counter width $clog2(TIMEOUT_CYCLES+1); no wrap within a transaction.

Reset
REQ-029 rst=0 immediately forces IDLE, counter 0, all strobes 0, data_mem_resp 0, data_rdata 0, latches 0, timeout_err 0, busy 0.
REQ-030 Reset mid-WAIT abandons transaction; no data_mem_resp pulse follows; late mem_resp after release is ignored in IDLE.

Structure
REQ-031 State enum dmem_state_t and default TIMEOUT constant go in rv32i_types package.
REQ-032 Single module; no sub-module (timeout counter inline).

Verification
REQ-033 Load: data_read=1, data_addr=0x1000_0006, mem_resp 3 cycles after mem_read, mem_rdata=0xDEADBEEF -> mem_addr=0x1000_0004, data_rdata=0xDEADBEEF with one-cycle data_mem_resp.
REQ-034 Store: data_write=1, wdata=0x1234_5678, mbe=4'b0011 -> mem_write held until mem_resp, mem_wdata/mem_mbe match, single resp pulse, data_rdata unchanged.
REQ-035 Timeout: TIMEOUT_CYCLES=8, mem_resp never -> strobe drops after 8 WAIT cycles, data_rdata=0, timeout_err=1 and stays set.
REQ-036 Simultaneous read+write, and requester held high through resp -> only load issued, exactly one mem transaction and one resp per request.
REQ-037 rst=0 asynchronously during WAIT, late mem_resp after release -> no data_mem_resp, all outputs at reset values, busy=0.
